count_wrap_tracker: RTL and testbench

COUNT_WRAP_TRACKER -- requirements
Module: count_wrap_tracker

---
 rtl/count_wrap_tracker.sv | 128 ++++++++++++
 tb/tb_count_wrap_tracker.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/count_wrap_tracker.sv
// Extends an upstream 4-bit up/down counter with a WRAP_W-bit wrap counter and wrap pulses.
// Optional macro WRAP_TRACKER_STEP_CHECK_EN adds the sticky fault port and FAULT state.
module count_wrap_tracker #(
    parameter int unsigned WRAP_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [3:0]            count,
    output logic                  wrap_up,
    output logic                  wrap_down,
    output logic [WRAP_W+3:0]     ext_count
`ifdef WRAP_TRACKER_STEP_CHECK_EN
    ,
    output logic                  fault
`endif
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = 4'hF;

`ifdef WRAP_TRACKER_STEP_CHECK_EN
    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_TRACK = 2'd1
    } state_t;
`endif

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    prev_q, prev_d;
    logic [WRAP_W-1:0]   wrap_hi_q, wrap_hi_d;
    logic                wrap_up_q, wrap_up_d;
    logic                wrap_down_q, wrap_down_d;
    logic [CNT_W-1:0]    delta;
`ifdef WRAP_TRACKER_STEP_CHECK_EN
    logic                fault_q, fault_d;
`endif

    assign delta = count - prev_q;

    // Next-state: prev always follows count; wrap_hi moves only on 15<->0 steps in TRACK.
    always_comb begin
        state_d     = state_q;
        prev_d      = count;
        wrap_hi_d   = wrap_hi_q;
        wrap_up_d   = 1'b0;
        wrap_down_d = 1'b0;
`ifdef WRAP_TRACKER_STEP_CHECK_EN
        fault_d     = fault_q;
`endif
        if (clear) begin
            state_d   = ST_INIT;
            wrap_hi_d = '0;
`ifdef WRAP_TRACKER_STEP_CHECK_EN
            fault_d   = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_INIT: begin
                    state_d = ST_TRACK;
                end
                ST_TRACK: begin
                    if (delta == 4'd1) begin
                        if (prev_q == CNT_MAX) begin
                            wrap_hi_d = wrap_hi_q + WRAP_W'(1);
                            wrap_up_d = 1'b1;
                        end
                    end else if (delta == CNT_MAX) begin
                        if (prev_q == 4'd0) begin
                            wrap_hi_d   = wrap_hi_q - WRAP_W'(1);
                            wrap_down_d = 1'b1;
                        end
`ifdef WRAP_TRACKER_STEP_CHECK_EN
                    end else if (delta != 4'd0) begin
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
`endif
                    end
                end
`ifdef WRAP_TRACKER_STEP_CHECK_EN
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
`endif
                default: begin
                    state_d = ST_INIT;
                end
            endcase
        end
    end

    // State and output registers; reset discards all history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_INIT;
            prev_q      <= '0;
            wrap_hi_q   <= '0;
            wrap_up_q   <= 1'b0;
            wrap_down_q <= 1'b0;
`ifdef WRAP_TRACKER_STEP_CHECK_EN
            fault_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            wrap_hi_q   <= wrap_hi_d;
            wrap_up_q   <= wrap_up_d;
            wrap_down_q <= wrap_down_d;
`ifdef WRAP_TRACKER_STEP_CHECK_EN
            fault_q     <= fault_d;
`endif
        end
    end

    assign wrap_up   = wrap_up_q;
    assign wrap_down = wrap_down_q;
    assign ext_count = {wrap_hi_q, prev_q};
`ifdef WRAP_TRACKER_STEP_CHECK_EN
    assign fault     = fault_q;
`endif

endmodule

// File: tb/tb_count_wrap_tracker.sv
// Scoreboard bench for count_wrap_tracker: directed vectors queue hand-computed expectations,
// a negedge monitor pops and compares. Honours WRAP_TRACKER_STEP_CHECK_EN like the DUT.
module tb_count_wrap_tracker;

    logic        clk;
    logic        reset;
    logic        clear;
    logic [3:0]  count;
    logic        wrap_up;
    logic        wrap_down;
    logic [11:0] ext_count;
`ifdef WRAP_TRACKER_STEP_CHECK_EN
    logic        fault;
`endif

    typedef struct {
        string       name;
        logic        up;
        logic        dn;
        logic [11:0] ext;
        logic        flt;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    count_wrap_tracker #(.WRAP_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .count     (count),
        .wrap_up   (wrap_up),
        .wrap_down (wrap_down),
        .ext_count (ext_count)
`ifdef WRAP_TRACKER_STEP_CHECK_EN
        ,
        .fault     (fault)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string nm, input logic up, input logic dn,
                        input logic [11:0] ext, input logic flt);
        exp_t e;
        e.name = nm;
        e.up   = up;
        e.dn   = dn;
        e.ext  = ext;
        e.flt  = flt;
        exp_q.push_back(e);
    endtask

    // One clock: inputs change on negedge, expectation queued just after the sampling edge.
    task automatic drive(input string nm, input logic rst, input logic clr, input logic [3:0] cnt,
                         input logic up, input logic dn, input logic [11:0] ext, input logic flt);
        @(negedge clk);
        reset = rst;
        clear = clr;
        count = cnt;
        @(posedge clk);
        #1;
        push(nm, up, dn, ext, flt);
    endtask

    // Monitor: outputs are stable at negedge; compare against the oldest expectation.
    initial begin
        exp_t e;
        logic bad;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                bad = (wrap_up !== e.up) || (wrap_down !== e.dn) || (ext_count !== e.ext);
`ifdef WRAP_TRACKER_STEP_CHECK_EN
                bad = bad || (fault !== e.flt);
                if (bad) begin
                    miscompares++;
                    $display("FAIL %s: got up=%0b dn=%0b ext=0x%03h fault=%0b, required up=%0b dn=%0b ext=0x%03h fault=%0b",
                             e.name, wrap_up, wrap_down, ext_count, fault, e.up, e.dn, e.ext, e.flt);
                end
`else
                if (bad) begin
                    miscompares++;
                    $display("FAIL %s: got up=%0b dn=%0b ext=0x%03h, required up=%0b dn=%0b ext=0x%03h",
                             e.name, wrap_up, wrap_down, ext_count, e.up, e.dn, e.ext);
                end
`endif
            end
        end
    end

    initial begin
        reset = 1'b1;
        clear = 1'b0;
        count = 4'd0;

        drive("rst_hold0", 1, 0, 4'd0, 0, 0, 12'h000, 0);
        drive("rst_hold1", 1, 0, 4'd5, 0, 0, 12'h000, 0);

        // Up-wrap after reset release; first edge only captures.
        drive("up_init13", 0, 0, 4'd13, 0, 0, 12'h00D, 0);
        drive("up_14",     0, 0, 4'd14, 0, 0, 12'h00E, 0);
        drive("up_15",     0, 0, 4'd15, 0, 0, 12'h00F, 0);
        drive("up_wrap0",  0, 0, 4'd0,  1, 0, 12'h010, 0);
        // Down-wrap back to wrap_hi=0.
        drive("dn_1",      0, 0, 4'd1,  0, 0, 12'h011, 0);
        drive("dn_0",      0, 0, 4'd0,  0, 0, 12'h010, 0);
        drive("dn_wrap15", 0, 0, 4'd15, 0, 1, 12'h00F, 0);
        drive("dn_14",     0, 0, 4'd14, 0, 0, 12'h00E, 0);

        // One up-wrap, climb to 7, then hold.
        drive("h_15",      0, 0, 4'd15, 0, 0, 12'h00F, 0);
        drive("h_wrap0",   0, 0, 4'd0,  1, 0, 12'h010, 0);
        for (int c = 1; c <= 7; c++)
            drive("h_climb", 0, 0, 4'(c), 0, 0, 12'(16 + c), 0);
        for (int i = 0; i < 50; i++)
            drive("hold7", 0, 0, 4'd7, 0, 0, 12'h017, 0);
        // Walk back down, wrap down, wrap up again.
        for (int c = 6; c >= 0; c--)
            drive("walk_dn", 0, 0, 4'(c), 0, 0, 12'(16 + c), 0);
        drive("w_dn15",    0, 0, 4'd15, 0, 1, 12'h00F, 0);
        drive("w_up0",     0, 0, 4'd0,  1, 0, 12'h010, 0);

        // Jump 4->9 from wrap_hi=1.
        for (int c = 1; c <= 4; c++)
            drive("pre_jump", 0, 0, 4'(c), 0, 0, 12'(16 + c), 0);
`ifdef WRAP_TRACKER_STEP_CHECK_EN
        drive("jump9_fault", 0, 0, 4'd9, 0, 0, 12'h019, 1);
        for (int c = 10; c <= 15; c++)
            drive("fault_track", 0, 0, 4'(c), 0, 0, 12'(16 + c), 1);
        drive("fault_frozen0", 0, 0, 4'd0, 0, 0, 12'h010, 1);
`else
        drive("jump9_resync", 0, 0, 4'd9, 0, 0, 12'h019, 0);
        for (int c = 10; c <= 15; c++)
            drive("post_jump", 0, 0, 4'(c), 0, 0, 12'(16 + c), 0);
        drive("post_jump_wrap", 0, 0, 4'd0, 1, 0, 12'h020, 0);
`endif

        // Clear with a would-be down-wrap step: clear wins, then INIT swallows 15->0.
        drive("clear_prio", 0, 1, 4'd15, 0, 0, 12'h00F, 0);
        drive("clr_init0",  0, 0, 4'd0,  0, 0, 12'h000, 0);
        drive("hi_0to255",  0, 0, 4'd15, 0, 1, 12'hFFF, 0);
        drive("hi_255to0",  0, 0, 4'd0,  1, 0, 12'h000, 0);

        // Three full up-wraps to reach wrap_hi=3.
        for (int w = 1; w <= 3; w++) begin
            for (int c = 1; c <= 15; c++)
                drive("to_hi3", 0, 0, 4'(c), 0, 0, 12'((w - 1) * 16 + c), 0);
            drive("to_hi3_wrap", 0, 0, 4'd0, 1, 0, 12'(w * 16), 0);
        end

        // Asynchronous reset mid-cycle: outputs zero before the next edge.
        @(posedge clk);
        #3;
        reset = 1'b1;
        push("async_rst", 0, 0, 12'h000, 0);
        drive("rst_held15", 1, 0, 4'd15, 0, 0, 12'h000, 0);
        drive("rel_init15", 0, 0, 4'd15, 0, 0, 12'h00F, 0);
        drive("rel_wrap0",  0, 0, 4'd0,  1, 0, 12'h010, 0);
        drive("rel_1",      0, 0, 4'd1,  0, 0, 12'h011, 0);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
